// File: rtl/j1_data_stack.sv
`default_nettype none
// ============================================================================
// Module      : j1_data_stack
// Description : J1 data stack. Registered top-of-stack over a circular
//               register file; depth tracking with sticky overflow/underflow.
// Revision    : 1.0 - initial release
// ============================================================================
module j1_data_stack #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       op_valid,
    input  logic [1:0]                 dsp_delta,
    input  logic                       tos_wen,
    input  logic                       t_to_n,
    input  logic [WIDTH-1:0]           alu_result,
    output logic [WIDTH-1:0]           tos,
    output logic [WIDTH-1:0]           nos,
    output logic [$clog2(DEPTH):0]     depth,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int              c_SPW     = $clog2(DEPTH);
    localparam int              c_DW      = c_SPW + 1;
    localparam logic [c_DW-1:0] c_FULL    = c_DW'(DEPTH);
    localparam logic [1:0]      c_D_ZERO  = 2'b00;
    localparam logic [1:0]      c_D_PUSH  = 2'b01;
    localparam logic [1:0]      c_D_POP2  = 2'b10;
    localparam logic [1:0]      c_D_POP1  = 2'b11;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_SPW-1:0] r_sp;
    logic [WIDTH-1:0] r_tos;
    logic [c_DW-1:0]  r_depth;
    logic             r_ovf;
    logic             r_unf;

    logic             w_exec;
    logic [c_SPW-1:0] w_sp_next;
    logic [c_DW-1:0]  w_depth_next;
    logic             w_ovf_set;
    logic             w_unf_set;
    logic             w_wr_en;
    logic [c_SPW-1:0] w_wr_addr;

    assign w_exec = op_valid & ~clear;

    always_comb begin
        w_sp_next    = r_sp;
        w_depth_next = r_depth;
        w_ovf_set    = 1'b0;
        w_unf_set    = 1'b0;
        w_wr_en      = 1'b0;
        w_wr_addr    = r_sp;
        case (dsp_delta)
            c_D_PUSH: begin
                w_sp_next = r_sp + c_SPW'(1);
                w_wr_en   = w_exec;
                w_wr_addr = r_sp + c_SPW'(1);
                // A push onto a full stack overwrites the oldest entry.
                if (r_depth == c_FULL) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_depth_next = r_depth + c_DW'(1);
                end
            end
            c_D_POP1: begin
                w_sp_next = r_sp - c_SPW'(1);
                if (r_depth == '0) begin
                    w_unf_set = 1'b1;
                end else begin
                    w_depth_next = r_depth - c_DW'(1);
                end
            end
            c_D_POP2: begin
                w_sp_next = r_sp - c_SPW'(2);
                if (r_depth < c_DW'(2)) begin
                    w_depth_next = '0;
                    w_unf_set    = 1'b1;
                end else begin
                    w_depth_next = r_depth - c_DW'(2);
                end
            end
            default: begin
                w_wr_en = w_exec & t_to_n;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tos   <= '0;
            r_sp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (clear) begin
            r_sp    <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (op_valid) begin
            r_sp    <= w_sp_next;
            r_depth <= w_depth_next;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
            if (tos_wen) begin
                r_tos <= alu_result;
            end
        end
    end

    // Storage is deliberately unreset; nos masking hides stale contents.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= r_tos;
        end
    end

    assign tos       = r_tos;
    assign nos       = (r_depth == '0) ? '0 : r_mem[r_sp];
    assign depth     = r_depth;
    assign full      = (r_depth == c_FULL);
    assign empty     = (r_depth == '0);
    assign overflow  = r_ovf;
    assign underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_j1_data_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_j1_data_stack
// Description : Directed bench for j1_data_stack with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_j1_data_stack;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    clear;
    logic                    op_valid;
    logic [1:0]              dsp_delta;
    logic                    tos_wen;
    logic                    t_to_n;
    logic [WIDTH-1:0]        alu_result;
    logic [WIDTH-1:0]        tos;
    logic [WIDTH-1:0]        nos;
    logic [$clog2(DEPTH):0]  depth;
    logic                    full;
    logic                    empty;
    logic                    overflow;
    logic                    underflow;

    j1_data_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (clear),
        .op_valid   (op_valid),
        .dsp_delta  (dsp_delta),
        .tos_wen    (tos_wen),
        .t_to_n     (t_to_n),
        .alu_result (alu_result),
        .tos        (tos),
        .nos        (nos),
        .depth      (depth),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Model: front of the queue is nos, back is the oldest entry.
    logic [WIDTH-1:0] m_tos;
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;
    bit               m_unf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_tos = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_apply(input bit clr, input bit v, input logic [1:0] d,
                               input bit twen, input bit ttn, input logic [WIDTH-1:0] res);
        logic [WIDTH-1:0] old;
        if (clr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (v) begin
            old = m_tos;
            case (d)
                2'b01: begin
                    m_q.push_front(old);
                    if (m_q.size() > DEPTH) begin
                        void'(m_q.pop_back());
                        m_ovf = 1'b1;
                    end
                end
                2'b00: if (ttn && m_q.size() > 0) m_q[0] = old;
                2'b11: begin
                    if (m_q.size() >= 1) void'(m_q.pop_front());
                    else m_unf = 1'b1;
                end
                default: begin
                    if (m_q.size() >= 2) begin
                        void'(m_q.pop_front());
                        void'(m_q.pop_front());
                    end else begin
                        m_q.delete();
                        m_unf = 1'b1;
                    end
                end
            endcase
            if (twen) m_tos = res;
        end
    endtask

    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_nos;
        if (chk_en) begin
            exp_nos = (m_q.size() > 0) ? m_q[0] : '0;
            chk("tos", tos, m_tos);
            chk("nos", nos, exp_nos);
            chk("depth", 32'(depth), 32'(m_q.size()));
            chk("full", 32'(full), 32'(m_q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(m_q.size() == 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("underflow", 32'(underflow), 32'(m_unf));
        end
    end

    task automatic step(input bit v, input logic [1:0] d, input bit twen, input bit ttn,
                        input logic [WIDTH-1:0] res, input bit clr);
        op_valid   = v;
        dsp_delta  = d;
        tos_wen    = twen;
        t_to_n     = ttn;
        alu_result = res;
        clear      = clr;
        @(posedge clk);
        model_apply(clr, v, d, twen, ttn, res);
        #1;
        op_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic push(input logic [WIDTH-1:0] res);
        step(1'b1, 2'b01, 1'b1, 1'b0, res, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; op_valid = 1'b0; dsp_delta = 2'b00;
        tos_wen = 1'b0; t_to_n = 1'b0; alu_result = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tos", tos, 32'h0);
        chk("rst_depth", 32'(depth), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_nos", nos, 32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Push sequence
        push(32'h11); push(32'h22); push(32'h33);
        chk("push_tos", tos, 32'h33);
        chk("push_nos", nos, 32'h22);
        chk("push_depth", 32'(depth), 32'd3);

        // Add-and-pop
        step(1'b1, 2'b11, 1'b1, 1'b0, 32'h55, 1'b0);
        chk("addpop_tos", tos, 32'h55);
        chk("addpop_nos", nos, 32'h11);
        chk("addpop_depth", 32'(depth), 32'd2);
        chk("addpop_flags", 32'({overflow, underflow}), 32'd0);

        // Idle cycle with garbage inputs
        step(1'b0, 2'b01, 1'b1, 1'b1, 32'hDEAD, 1'b0);
        chk("idle_tos", tos, 32'h55);
        chk("idle_depth", 32'(depth), 32'd2);

        // Clear alone
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("clr_depth", 32'(depth), 32'd0);
        chk("clr_tos", tos, 32'h55);

        // Swap
        push(32'hB); push(32'hA);
        step(1'b1, 2'b00, 1'b1, 1'b1, 32'hB, 1'b0);
        chk("swap_tos", tos, 32'hB);
        chk("swap_nos", nos, 32'hA);
        chk("swap_depth", 32'(depth), 32'd2);

        // t_to_n ignored on push and pop
        step(1'b1, 2'b01, 1'b1, 1'b1, 32'hC, 1'b0);
        chk("ttn_push_nos", nos, 32'hB);
        step(1'b1, 2'b10, 1'b0, 1'b1, 32'h0, 1'b0);
        chk("pop2_nos", nos, 32'h55);
        chk("pop2_depth", 32'(depth), 32'd1);

        // Underflow from depth 1
        step(1'b1, 2'b10, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("unf_depth", 32'(depth), 32'd0);
        chk("unf_flag", 32'(underflow), 32'd1);
        chk("unf_nos", nos, 32'h0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("unf_clr_flag", 32'(underflow), 32'd0);
        chk("unf_clr_tos", tos, 32'hC);

        // Overflow: 17 pushes, then drain
        for (int i = 1; i <= DEPTH + 1; i++) push(WIDTH'(i));
        chk("ovf_depth", 32'(depth), 32'd16);
        chk("ovf_full", 32'(full), 32'd1);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_tos", tos, 32'd17);
        chk("ovf_nos", nos, 32'd16);
        for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_bottom", nos, 32'd1);
        step(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_no_unf", 32'(underflow), 32'd0);
        step(1'b1, 2'b11, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("pop_empty_unf", 32'(underflow), 32'd1);

        // Refill after wrap, then clear with a simultaneous op
        push(32'h71); push(32'h72);
        chk("refill_nos", nos, 32'h71);
        step(1'b1, 2'b01, 1'b1, 1'b0, 32'hEE, 1'b1);
        chk("prio_tos", tos, 32'h72);
        chk("prio_depth", 32'(depth), 32'd0);
        chk("prio_flags", 32'({overflow, underflow}), 32'd0);

        // Asynchronous reset between edges
        push(32'h81); push(32'h82);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_tos", tos, 32'h0);
        chk("arst_depth", 32'(depth), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        push(32'h91); push(32'h92);
        chk("post_rst_nos", nos, 32'h91);
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
